// File: rtl/aes_encrypt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_encrypt_ctrl
// Brief    : Iterative AES-128 encryptor, one round and one key-schedule step
//            per cycle.
// Revision : 1.0
// ============================================================================
module aes_encrypt_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter bit ZEROIZE    = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [3:0]   round_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 4; i++) o[32*i +: 32] = sub_word(s[32*i +: 32]);
        return o;
    endfunction

    // Byte n of the block sits at [127-8n -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic logic [127:0] encrypt_round(input logic [127:0] s, input logic [127:0] k);
        return mix_columns(shift_rows(sub_bytes(s))) ^ k;
    endfunction

    function automatic logic [127:0] keystep(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        rk_d        = rk_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    st_d    = in_data ^ key_in;
                    rk_d    = keystep(key_in, 8'h01);
                    cnt_d   = 4'd1;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                st_d  = encrypt_round(st_q, rk_q);
                rk_d  = keystep(rk_q, rcon(cnt_q + 4'd1));
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(NUM_ROUNDS - 1)) state_d = S_FINAL;
            end
            S_FINAL: begin
                out_data_d  = shift_rows(sub_bytes(st_q)) ^ rk_q;
                out_valid_d = 1'b1;
                cnt_d       = 4'd0;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    if (ZEROIZE) begin
                        st_d       = '0;
                        rk_d       = '0;
                        out_data_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            st_q        <= '0;
            rk_q        <= '0;
            cnt_q       <= 4'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_ROUND) || (state_q == S_FINAL);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign round_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_encrypt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_encrypt_ctrl
// Brief    : Directed known-answer bench for aes_encrypt_ctrl.
// Revision : 1.0
// ============================================================================
module tb_aes_encrypt_ctrl;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic [3:0]   round_cnt;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] C_PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
        int           hold;
    } vec_t;

    vec_t vecs[4];

    aes_encrypt_ctrl #(.NUM_ROUNDS(10), .ZEROIZE(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .round_cnt (round_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid (bounded), checks latency/busy/round_cnt, then completes the handshake.
    task automatic wait_output(input logic [127:0] ct, input int hold);
        int lat;
        int busy_cnt;
        lat      = 0;
        busy_cnt = 0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_cnt++;
            chk_int("round_cnt_step", int'(round_cnt), lat + 1);
            in_data = {$urandom, $urandom, $urandom, $urandom};
            key_in  = {$urandom, $urandom, $urandom, $urandom};
            tick();
            lat++;
        end
        chk_int("latency", lat, 10);
        chk_int("busy_cycles", busy_cnt, 10);
        check("ciphertext", out_data, ct);
        chk_int("round_cnt_done", int'(round_cnt), 0);
        chk1("in_ready_done", in_ready, 1'b0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk1("bp_out_valid", out_valid, 1'b1);
            check("bp_out_data", out_data, ct);
            chk1("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        chk1("hs_out_valid", out_valid, 1'b0);
        chk1("hs_in_ready", in_ready, 1'b1);
        check("zero_out_data", out_data, 128'h0);
        check("zero_st", dut.st_q, 128'h0);
        check("zero_rk", dut.rk_q, 128'h0);
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] ct, input int hold);
        out_ready = (hold == 0);
        in_data   = pt;
        key_in    = key;
        in_valid  = 1'b1;
        chk1("in_ready_idle", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk1("busy_after_accept", busy, 1'b1);
        wait_output(ct, hold);
        out_ready = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int cyc;
        vecs[0] = '{pt: C_PT_B,  key: C_KEY_B, ct: C_CT_B, hold: 0};
        vecs[1] = '{pt: C_PT_C,  key: C_KEY_C, ct: C_CT_C, hold: 0};
        vecs[2] = '{pt: 128'h0,  key: 128'h0,  ct: C_CT_Z, hold: 0};
        vecs[3] = '{pt: C_PT_C,  key: C_KEY_C, ct: C_CT_C, hold: 20};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        key_in    = '0;
        out_ready = 1'b0;
        #12;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 128'h0);
        chk1("rst_busy", busy, 1'b0);
        chk_int("rst_round_cnt", int'(round_cnt), 0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_block(vecs[i].pt, vecs[i].key, vecs[i].ct, vecs[i].hold);

        // Back-to-back: in_valid stays high, second block queued while the first runs.
        out_ready = 1'b1;
        in_data   = C_PT_B;
        key_in    = C_KEY_B;
        in_valid  = 1'b1;
        tick();
        cyc = 0;
        while (!in_ready && cyc < 40) begin
            if (out_valid) begin
                check("b2b_ct0", out_data, C_CT_B);
                in_data = C_PT_C;
                key_in  = C_KEY_C;
            end else begin
                in_data = {$urandom, $urandom, $urandom, $urandom};
                key_in  = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
            cyc++;
        end
        chk_int("b2b_period", cyc + 1, 12);
        tick();
        in_valid = 1'b0;
        chk1("b2b_accept2", busy, 1'b1);
        wait_output(C_CT_C, 0);
        out_ready = 1'b0;

        // Asynchronous reset in the middle of round 5.
        in_data  = C_PT_B;
        key_in   = C_KEY_B;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (round_cnt != 4'd5 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk_int("mid_reach_r5", int'(round_cnt), 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_in_ready", in_ready, 1'b1);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_data", out_data, 128'h0);
        chk_int("mid_rst_round_cnt", int'(round_cnt), 0);
        check("mid_rst_st", dut.st_q, 128'h0);
        tick();
        rst_n = 1'b1;
        tick();
        run_block(C_PT_B, C_KEY_B, C_CT_B, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
